// File: rtl/ram_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter_pkg
// Shared definitions for the RAM port arbiter family.
//   - tag_width(): width of a requester index (clog2 of requester count)
//   - MAX_NREQ / MAX_TAG_W: largest supported requester count and its tag
//   - MAX_RD_LAT: deepest RAM read latency the tag pipeline is meant for
//   - lock_state_t: encoding of the optional burst-lock state
// No ports (package).
// ---------------------------------------------------------------------------
package ram_port_arbiter_pkg;

  localparam int MAX_NREQ   = 8;
  localparam int MAX_TAG_W  = 3;
  localparam int MAX_RD_LAT = 3;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_t;

  // A single requester still needs a one-bit tag.
  function automatic int tag_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority encoder. Returns the first set bit of
// 'eligible' searching upward from (ptr+1) mod N with wrap-around.
// Ports:
//   eligible  in  N   candidate requesters
//   ptr       in  TW  index of the most recent winner
//   winner    out TW  index of the selected requester (0 when none)
//   any       out 1   at least one requester is eligible
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 4,
  parameter int TW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [TW-1:0] ptr,
  output logic [TW-1:0] winner,
  output logic          any
);

  logic [TW-1:0] idx;

  // Scan from the farthest position back to the nearest so the nearest
  // eligible requester after ptr is the last one written and thus wins.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = N; k >= 1; k--) begin
      idx = TW'((int'(ptr) + k) % N);
      if (eligible[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
// Shares one synchronous block-RAM port between NREQ requesters using
// round-robin arbitration. One RAM command per cycle; read data is routed
// back to the issuing requester with a one-cycle rvalid pulse, RD_LAT+1
// cycles after its gnt.
// Optional macro RAM_ARB_LOCK_EN adds a 'lock' input: a winner holding lock
// keeps the port every cycle until it drops lock or req.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req, we           per-requester request (level) and write enable
//   addr, wdata       flattened per-requester address / write data
//   lock              (RAM_ARB_LOCK_EN only) per-requester burst lock
//   gnt, rvalid       one-hot grant pulse / read-data-valid pulse
//   rdata             shared read data, valid with rvalid
//   ram_addr/din/we   RAM command port
//   ram_dout          RAM read data
// ---------------------------------------------------------------------------
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int AW     = 11,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
`ifdef RAM_ARB_LOCK_EN
  input  logic [NREQ-1:0]   lock,
`endif
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [DW-1:0]     rdata,
  output logic [AW-1:0]     ram_addr,
  output logic [DW-1:0]     ram_din,
  output logic              ram_we,
  input  logic [DW-1:0]     ram_dout
);

  localparam int TW = tag_width(NREQ);

  logic [TW-1:0]   ptr;
  logic [TW-1:0]   winner;
  logic            any;
  logic [NREQ-1:0] eligible;
  logic [TW-1:0]   grant_idx;
  logic            grant_valid;

  // Stage 0 is loaded at the grant edge; stage RD_LAT lines up with the
  // edge where ram_dout holds the data for that command.
  logic [RD_LAT:0] tag_vld;
  logic [TW-1:0]   tag_id [0:RD_LAT];

  rr_pick #(.N(NREQ), .TW(TW)) u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .winner   (winner),
    .any      (any)
  );

`ifdef RAM_ARB_LOCK_EN
  lock_state_t state, state_next;

  // While locked the owner is always ptr, since every grant updates ptr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOCK_IDLE;
    else        state <= state_next;
  end

  // Masking with the registered gnt stops a requester winning on two
  // consecutive cycles, except for a locked owner which bursts freely.
  always_comb begin
    eligible    = req & ~gnt;
    state_next  = state;
    grant_idx   = winner;
    grant_valid = any;
    if (state == LOCK_HELD && lock[ptr] && req[ptr]) begin
      grant_idx   = ptr;
      grant_valid = 1'b1;
    end else begin
      state_next = (any && lock[winner]) ? LOCK_HELD : LOCK_IDLE;
    end
  end
`else
  // Masking with the registered gnt stops a requester winning on two
  // consecutive cycles, so a lone requester gets every other cycle.
  always_comb begin
    eligible    = req & ~gnt;
    grant_idx   = winner;
    grant_valid = any;
  end
`endif

  // Present the winner's command to the RAM in the same cycle gnt is high.
  // ram_addr and ram_din hold their last value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      ptr      <= TW'(NREQ - 1);
    end else if (grant_valid) begin
      gnt      <= NREQ'(1) << grant_idx;
      ram_we   <= we[grant_idx];
      ram_addr <= addr[grant_idx*AW +: AW];
      ram_din  <= wdata[grant_idx*DW +: DW];
      ptr      <= grant_idx;
    end else begin
      gnt    <= '0;
      ram_we <= 1'b0;
    end
  end

  // Tag pipeline: only reads enter it, so writes never produce rvalid.
  // Responses leave in issue order; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      for (int i = 0; i <= RD_LAT; i++) tag_id[i] <= '0;
      rvalid  <= '0;
      rdata   <= '0;
    end else begin
      tag_vld[0] <= grant_valid & ~we[grant_idx];
      tag_id[0]  <= grant_idx;
      for (int i = 1; i <= RD_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
      if (tag_vld[RD_LAT]) begin
        rvalid <= NREQ'(1) << tag_id[RD_LAT];
        rdata  <= ram_dout;
      end else begin
        rvalid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_port_arbiter
// Directed bench for ram_port_arbiter with a small behavioural write-first
// RAM attached to the RAM port. Expected values are written out by hand.
// Define RAM_ARB_LOCK_EN to also exercise the burst-lock path.
// ---------------------------------------------------------------------------
module tb_ram_port_arbiter;

  localparam int NREQ   = 4;
  localparam int AW     = 11;
  localparam int DW     = 32;
  localparam int RD_LAT = 1;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
`ifdef RAM_ARB_LOCK_EN
  logic [NREQ-1:0]    lock;
`endif
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic [AW-1:0]      ram_addr;
  logic [DW-1:0]      ram_din;
  logic               ram_we;
  logic [DW-1:0]      ram_dout;

  int compared   = 0;
  int mismatched = 0;

  ram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
`ifdef RAM_ARB_LOCK_EN
    .lock     (lock),
`endif
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural write-first RAM with RD_LAT cycles of read latency.
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] rd_pipe [0:RD_LAT-1];

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    rd_pipe[0] <= ram_we ? ram_din : mem[ram_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign ram_dout = rd_pipe[RD_LAT-1];

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ-1:0] w);
    req = r;
    we  = w;
  endtask

  task automatic setPort(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  // Advance one clock and sample just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [NREQ-1:0] exp_gnt [1:7];
  logic [NREQ-1:0] exp_rv  [1:7];
  logic [DW-1:0]   exp_rd  [1:7];

  initial begin
    rst_n = 1'b0;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
`ifdef RAM_ARB_LOCK_EN
    lock  = '0;
`endif
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    for (int i = 0; i < NREQ; i++) begin
      mem[16 + i] = 32'hA000_0000 + i;
      setPort(i, AW'(16 + i), '0);
    end
    mem[11'h123] = 32'h1111_1111;

    // Reset held with every requester asking.
    applyStimulus(4'b1111, 4'b0000);
    repeat (3) tick();
    checkOutput("rst_gnt",    gnt,      0);
    checkOutput("rst_rvalid", rvalid,   0);
    checkOutput("rst_ram_we", ram_we,   0);
    checkOutput("rst_ram_addr", ram_addr, 0);
    checkOutput("rst_rdata",  rdata,    0);

    // Fairness: all four reading; rvalid two cycles after each gnt.
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000};
    exp_rv  = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_rd  = '{32'h0, 32'h0, 32'hA000_0000, 32'hA000_0001, 32'hA000_0002,
                32'hA000_0003, 32'hA000_0000};
    rst_n = 1'b1;
    for (int s = 1; s <= 7; s++) begin
      tick();
      checkOutput($sformatf("fair_gnt%0d", s), gnt, exp_gnt[s]);
      checkOutput($sformatf("fair_rvalid%0d", s), rvalid, exp_rv[s]);
      if (exp_rv[s] != 0) checkOutput($sformatf("fair_rdata%0d", s), rdata, exp_rd[s]);
      if (s == 5) applyStimulus(4'b0000, 4'b0000);
    end

    // Idle: no write strobe, address holds the last grant (r0, 0x010).
    tick();
    checkOutput("idle_gnt",      gnt,      0);
    checkOutput("idle_ram_we",   ram_we,   0);
    checkOutput("idle_ram_addr", ram_addr, 11'h010);

    // Write then read of the same address on consecutive cycles.
    setPort(1, 11'h123, 32'hDEAD_BEEF);
    setPort(2, 11'h123, 32'h0);
    applyStimulus(4'b0110, 4'b0010);
    tick();
    checkOutput("wr_gnt",      gnt,      4'b0010);
    checkOutput("wr_ram_we",   ram_we,   1);
    checkOutput("wr_ram_addr", ram_addr, 11'h123);
    checkOutput("wr_ram_din",  ram_din,  32'hDEAD_BEEF);
    applyStimulus(4'b0100, 4'b0000);
    tick();
    checkOutput("rd_gnt",      gnt,      4'b0100);
    checkOutput("rd_ram_we",   ram_we,   0);
    checkOutput("rd_ram_addr", ram_addr, 11'h123);
    applyStimulus(4'b0000, 4'b0000);
    tick();
    checkOutput("wr_no_rvalid", rvalid, 0);
    tick();
    checkOutput("rd_rvalid", rvalid, 4'b0100);
    checkOutput("rd_rdata",  rdata,  32'hDEAD_BEEF);
    tick();
    checkOutput("rd_rvalid_end", rvalid, 0);

    // Single requester held: grant every other cycle.
    setPort(2, 11'h012, 32'h0);
    applyStimulus(4'b0100, 4'b0000);
    for (int s = 1; s <= 6; s++) begin
      tick();
      checkOutput($sformatf("single_gnt%0d", s), gnt, (s % 2 == 1) ? 4'b0100 : 4'b0000);
      checkOutput($sformatf("single_rvalid%0d", s), rvalid,
                  (s >= 3 && s % 2 == 1) ? 4'b0100 : 4'b0000);
      if (s >= 3 && s % 2 == 1) checkOutput($sformatf("single_rdata%0d", s), rdata, 32'hA000_0002);
    end
    applyStimulus(4'b0000, 4'b0000);
    repeat (3) tick();

    // Reset during an outstanding read: its rvalid must never appear.
    applyStimulus(4'b0001, 4'b0000);
    tick();
    checkOutput("mid_gnt", gnt, 4'b0001);
    applyStimulus(4'b0000, 4'b0000);
    tick();
    checkOutput("mid_rvalid_pre", rvalid, 0);
    rst_n = 1'b0;
    tick();
    checkOutput("mid_rst_rvalid", rvalid, 0);
    checkOutput("mid_rst_gnt",    gnt,    0);
    rst_n = 1'b1;
    for (int s = 1; s <= 4; s++) begin
      tick();
      checkOutput($sformatf("mid_post_rvalid%0d", s), rvalid, 0);
    end

`ifdef RAM_ARB_LOCK_EN
    // r3 bursts under lock for four cycles while r0 waits.
    lock = 4'b1000;
    applyStimulus(4'b1000, 4'b0000);
    tick();
    checkOutput("lock_gnt1", gnt, 4'b1000);
    applyStimulus(4'b1001, 4'b0000);
    for (int s = 2; s <= 4; s++) begin
      tick();
      checkOutput($sformatf("lock_gnt%0d", s), gnt, 4'b1000);
    end
    lock = 4'b0000;
    tick();
    checkOutput("lock_exit_gnt", gnt, 4'b0001);
    applyStimulus(4'b0000, 4'b0000);
    repeat (3) tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
